// File: rtl/lru_cache_assoc.sv
// Fully-associative blocking LRU cache between a lookup frontend and a backing store.
// Optional hit/miss counters are enabled by defining LRU_CACHE_STATS_EN.
module lru_cache_assoc #(
    parameter int unsigned TAG_WIDTH  = 48,
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fe_req_valid,
    output logic                  fe_req_ready,
    input  logic [TAG_WIDTH-1:0]  fe_req_tag,
    output logic                  fe_rsp_valid,
    input  logic                  fe_rsp_ready,
    output logic [DATA_WIDTH-1:0] fe_rsp_data,
    output logic                  fe_rsp_hit,
    output logic                  be_req_valid,
    input  logic                  be_req_ready,
    output logic [TAG_WIDTH-1:0]  be_req_tag,
    input  logic                  be_rsp_valid,
    output logic                  be_rsp_ready,
    input  logic [DATA_WIDTH-1:0] be_rsp_data,
`ifdef LRU_CACHE_STATS_EN
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
`endif
    input  logic                  flush
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MREQ  = 2'd1;
    localparam logic [1:0] S_MWAIT = 2'd2;

    logic [1:0]            r_state;
    logic                  r_rdy_en;
    logic [DEPTH-1:0]      r_valid;
    logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [IDX_W-1:0]      r_rank [DEPTH];
    logic [TAG_WIDTH-1:0]  r_miss_tag;
    logic                  r_flush_pend;
    logic                  r_rsp_valid;
    logic                  r_rsp_hit;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic             w_hit;
    logic [IDX_W-1:0] w_hit_idx;
    logic             w_inv_found;
    logic [IDX_W-1:0] w_inv_idx;
    logic [IDX_W-1:0] w_lru_idx;
    logic [IDX_W-1:0] w_vict_idx;
    logic             w_accept;
    logic             w_fill;
    logic             w_touch_en;
    logic [IDX_W-1:0] w_touch_idx;
    logic [IDX_W-1:0] w_touch_rank;
    logic             w_flush_now;

    always_comb begin
        w_hit       = 1'b0;
        w_hit_idx   = '0;
        w_inv_found = 1'b0;
        w_inv_idx   = '0;
        w_lru_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == fe_req_tag)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
            if (!r_valid[i] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_idx   = IDX_W'(i);
            end
            if (r_rank[i] == IDX_W'(DEPTH - 1)) w_lru_idx = IDX_W'(i);
        end
    end

    // Handshake outputs are gated by rstn so nothing transfers during the synchronous reset cycle.
    assign fe_req_ready = rstn && r_rdy_en && (r_state == S_IDLE) && (!r_rsp_valid || fe_rsp_ready);
    assign be_req_valid = rstn && (r_state == S_MREQ);
    assign be_rsp_ready = rstn && (r_state == S_MWAIT);
    assign be_req_tag   = r_miss_tag;
    assign fe_rsp_valid = r_rsp_valid;
    assign fe_rsp_hit   = r_rsp_hit;
    assign fe_rsp_data  = r_rsp_data;

    assign w_accept     = fe_req_valid && fe_req_ready;
    assign w_fill       = be_rsp_valid && be_rsp_ready;
    assign w_vict_idx   = w_inv_found ? w_inv_idx : w_lru_idx;
    assign w_touch_en   = (w_accept && w_hit) || w_fill;
    assign w_touch_idx  = w_fill ? w_vict_idx : w_hit_idx;
    assign w_touch_rank = r_rank[w_touch_idx];
    // A flush seen while busy is deferred so it lands after the victim fill.
    assign w_flush_now  = ((r_state == S_IDLE) && flush) || (w_fill && (r_flush_pend || flush));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_rdy_en     <= 1'b0;
            r_valid      <= '0;
            r_miss_tag   <= '0;
            r_flush_pend <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_hit    <= 1'b0;
            r_rsp_data   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_rank[i] <= IDX_W'(i);
        end else begin
            r_rdy_en <= 1'b1;
            if (r_rsp_valid && fe_rsp_ready) r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_hit   <= 1'b1;
                            r_rsp_data  <= r_data[w_hit_idx];
                        end else begin
                            r_state    <= S_MREQ;
                            r_miss_tag <= fe_req_tag;
                        end
                    end
                end
                S_MREQ: if (be_req_ready) r_state <= S_MWAIT;
                S_MWAIT: begin
                    if (w_fill) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= 1'b0;
                        r_rsp_data  <= be_rsp_data;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_fill)                              r_flush_pend <= 1'b0;
            else if ((r_state != S_IDLE) && flush)   r_flush_pend <= 1'b1;

            if (w_flush_now) r_valid <= '0;
            else if (w_fill) r_valid[w_vict_idx] <= 1'b1;

            if (w_touch_en) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (IDX_W'(i) == w_touch_idx)     r_rank[i] <= '0;
                    else if (r_rank[i] < w_touch_rank) r_rank[i] <= r_rank[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_vict_idx]  <= r_miss_tag;
            r_data[w_vict_idx] <= be_rsp_data;
        end
    end

`ifdef LRU_CACHE_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (w_accept) begin
            if (w_hit && (r_stat_hits != '1))         r_stat_hits   <= r_stat_hits + 32'd1;
            if (!w_hit && (r_stat_misses != '1))      r_stat_misses <= r_stat_misses + 32'd1;
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`endif

endmodule

// File: tb/tb_lru_cache_assoc.sv
// Self-checking bench for lru_cache_assoc: recency-queue reference model, directed scenarios, random traffic.
// Stat outputs are checked when LRU_CACHE_STATS_EN is defined.
module tb_lru_cache_assoc;

    localparam int unsigned TW    = 16;
    localparam int unsigned DW    = 64;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fe_req_valid, fe_req_ready;
    logic [TW-1:0] fe_req_tag;
    logic          fe_rsp_valid, fe_rsp_ready, fe_rsp_hit;
    logic [DW-1:0] fe_rsp_data;
    logic          be_req_valid, be_req_ready;
    logic [TW-1:0] be_req_tag;
    logic          be_rsp_valid, be_rsp_ready;
    logic [DW-1:0] be_rsp_data;
    logic          flush;
`ifdef LRU_CACHE_STATS_EN
    logic [31:0]   stat_hits, stat_misses;
`endif

    lru_cache_assoc #(.TAG_WIDTH(TW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .fe_req_valid(fe_req_valid), .fe_req_ready(fe_req_ready), .fe_req_tag(fe_req_tag),
        .fe_rsp_valid(fe_rsp_valid), .fe_rsp_ready(fe_rsp_ready), .fe_rsp_data(fe_rsp_data),
        .fe_rsp_hit(fe_rsp_hit),
        .be_req_valid(be_req_valid), .be_req_ready(be_req_ready), .be_req_tag(be_req_tag),
        .be_rsp_valid(be_rsp_valid), .be_rsp_ready(be_rsp_ready), .be_rsp_data(be_rsp_data),
`ifdef LRU_CACHE_STATS_EN
        .stat_hits(stat_hits), .stat_misses(stat_misses),
`endif
        .flush(flush)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] bedata(input logic [TW-1:0] t);
        if (t == 16'h1234) return 64'hAAAA_AAAA_AAAA_AAAA;
        return {t, ~t, t ^ 16'h5A5A, t + 16'h0101};
    endfunction

    // Reference model: per-line valid/tag/data plus a recency queue of line indices (front = MRU).
    logic          m_init = 1'b0, m_rst, m_up, m_pend, m_rsp_valid, m_rsp_hit;
    logic [DW-1:0] m_rsp_data;
    logic [TW-1:0] m_miss_tag;
    int            m_phase;
    logic          m_valid [DEPTH];
    logic [TW-1:0] m_tag   [DEPTH];
    logic [DW-1:0] m_data  [DEPTH];
    int            m_q[$];
    logic [31:0]   m_hits, m_misses;
    logic          ev_acc = 1'b0, ev_bereq = 1'b0, ev_bersp = 1'b0;

    task automatic touch(input int e);
        for (int k = 0; k < m_q.size(); k++) begin
            if (m_q[k] == e) begin
                m_q.delete(k);
                break;
            end
        end
        m_q.push_front(e);
    endtask

    task automatic clear_valid();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        int hl, v, ph;
        logic acc;
        forever begin
            @(posedge clk);
            ev_acc = 1'b0; ev_bereq = 1'b0; ev_bersp = 1'b0;
            if (!rstn) begin
                m_init = 1'b1; m_rst = 1'b1; m_up = 1'b0; m_phase = 0; m_pend = 1'b0;
                m_miss_tag = '0; m_rsp_valid = 1'b0; m_rsp_hit = 1'b0; m_rsp_data = '0;
                m_hits = '0; m_misses = '0;
                m_q.delete();
                for (int i = 0; i < DEPTH; i++) begin
                    m_valid[i] = 1'b0;
                    m_q.push_back(i);
                end
            end else begin
                m_rst = 1'b0;
                ph  = m_phase;
                acc = fe_req_valid && m_up && (ph == 0) && (!m_rsp_valid || fe_rsp_ready);
                if (m_rsp_valid && fe_rsp_ready) m_rsp_valid = 1'b0;
                if (ph == 0) begin
                    if (acc) begin
                        ev_acc = 1'b1;
                        hl = -1;
                        for (int i = 0; i < DEPTH; i++)
                            if (m_valid[i] && m_tag[i] == fe_req_tag) hl = i;
                        if (hl >= 0) begin
                            m_rsp_valid = 1'b1; m_rsp_hit = 1'b1; m_rsp_data = m_data[hl];
                            touch(hl);
                            if (m_hits != 32'hFFFF_FFFF) m_hits++;
                        end else begin
                            m_phase = 1; m_miss_tag = fe_req_tag;
                            if (m_misses != 32'hFFFF_FFFF) m_misses++;
                        end
                    end
                    if (flush) clear_valid();
                end else if (ph == 1) begin
                    if (flush) m_pend = 1'b1;
                    if (be_req_ready) begin
                        m_phase = 2; ev_bereq = 1'b1;
                    end
                end else begin
                    if (flush) m_pend = 1'b1;
                    if (be_rsp_valid) begin
                        v = -1;
                        for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && v < 0) v = i;
                        if (v < 0) v = m_q[DEPTH-1];
                        m_valid[v] = 1'b1; m_tag[v] = m_miss_tag; m_data[v] = be_rsp_data;
                        touch(v);
                        m_rsp_valid = 1'b1; m_rsp_hit = 1'b0; m_rsp_data = be_rsp_data;
                        m_phase = 0; ev_bersp = 1'b1;
                        if (m_pend) clear_valid();
                        m_pend = 1'b0;
                    end
                end
                m_up = 1'b1;
            end
        end
    end

    // Per-cycle compare of all DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("fe_req_ready", fe_req_ready,
                    rstn && m_up && (m_phase == 0) && (!m_rsp_valid || fe_rsp_ready));
                chk("fe_rsp_valid", fe_rsp_valid, m_rsp_valid);
                if (m_rsp_valid || m_rst) begin
                    chk("fe_rsp_data", fe_rsp_data, m_rsp_data);
                    chk("fe_rsp_hit", fe_rsp_hit, m_rsp_hit);
                end
                chk("be_req_valid", be_req_valid, rstn && (m_phase == 1));
                chk("be_rsp_ready", be_rsp_ready, rstn && (m_phase == 2));
                if (m_phase == 1 || m_rst) chk("be_req_tag", be_req_tag, m_miss_tag);
`ifdef LRU_CACHE_STATS_EN
                chk("stat_hits", stat_hits, m_hits);
                chk("stat_misses", stat_misses, m_misses);
`endif
            end
        end
    end

    // Backend responder: random request acceptance and random fill latency.
    logic          be_stall = 1'b0, be_stale = 1'b0, bk_resp;
    int            bk_cnt;
    logic [TW-1:0] bk_tag;

    initial begin
        be_req_ready = 1'b0; be_rsp_valid = 1'b0; be_rsp_data = '0;
        bk_cnt = -1; bk_resp = 1'b0; bk_tag = '0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                be_req_ready = 1'b0;
                be_rsp_valid = be_stale;
                be_rsp_data  = '1;
                bk_cnt = -1; bk_resp = 1'b0;
            end else begin
                if (ev_bersp) bk_resp = 1'b0;
                if (!bk_resp) be_rsp_valid = 1'b0;
                if (ev_bereq) begin
                    bk_cnt = $urandom_range(2, 5);
                    bk_tag = m_miss_tag;
                end
                if (bk_cnt > 0) bk_cnt--;
                else if (bk_cnt == 0 && !be_stall) begin
                    be_rsp_valid = 1'b1; be_rsp_data = bedata(bk_tag);
                    bk_resp = 1'b1; bk_cnt = -1;
                end
                be_req_ready = ($urandom_range(0, 1) == 1);
            end
        end
    end

    task automatic send(input logic [TW-1:0] t);
        fe_req_valid = 1'b1; fe_req_tag = t;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (ev_acc) break;
        end
        chk("send_accept", ev_acc, 1'b1);
        fe_req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic h, output logic [DW-1:0] d);
        logic ok = 1'b0;
        h = 1'bx; d = 'x;
        for (int k = 0; k < 200; k++) begin
            if (fe_rsp_valid) begin
                h = fe_rsp_hit; d = fe_rsp_data; ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rsp_timeout", ok, 1'b1);
    endtask

    task automatic do_req(input logic [TW-1:0] t, output logic h, output logic [DW-1:0] d);
        send(t);
        get_rsp(h, d);
    endtask

    task automatic wait_mwait();
        for (int k = 0; k < 200; k++) begin
            if (m_phase == 2) break;
            @(posedge clk); #1;
        end
        chk("reach_mwait", (m_phase == 2), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic          h;
        logic [DW-1:0] d;
        logic [TW-1:0] bb [3];
        rstn = 1'b0; fe_req_valid = 1'b0; fe_req_tag = '0; fe_rsp_ready = 1'b1; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", fe_rsp_valid, 1'b0);
        chk("rst_rsp_data", fe_rsp_data, 64'h0);
        chk("rst_be_req_valid", be_req_valid, 1'b0);
        chk("rst_be_req_tag", be_req_tag, 16'h0);
        rstn = 1'b1;
        chk("ready_at_release", fe_req_ready, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_release", fe_req_ready, 1'b1);

        // Cold miss, then hit with latency 1.
        send(16'h1234);
        chk("cold_be_req_valid", be_req_valid, 1'b1);
        chk("cold_be_req_tag", be_req_tag, 16'h1234);
        get_rsp(h, d);
        chk("cold_hit", h, 1'b0);
        chk("cold_data", d, 64'hAAAA_AAAA_AAAA_AAAA);
        send(16'h1234);
        chk("rehit_latency", fe_rsp_valid, 1'b1);
        chk("rehit_hit", fe_rsp_hit, 1'b1);
        chk("rehit_data", fe_rsp_data, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("rehit_no_be_req", be_req_valid, 1'b0);

        // LRU eviction.
        for (int t = 1; t <= 8; t++) do_req(TW'(t), h, d);
        do_req(16'd1, h, d);
        chk("touch1_hit", h, 1'b1);
        do_req(16'd9, h, d);
        chk("tag9_miss", h, 1'b0);
        do_req(16'd2, h, d);
        chk("evicted2_miss", h, 1'b0);
        do_req(16'd1, h, d);
        chk("kept1_hit", h, 1'b1);
        do_req(16'd3, h, d);

        // Back-to-back hits.
        bb[0] = 16'd1; bb[1] = 16'd2; bb[2] = 16'd3;
        fe_req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fe_req_tag = bb[i];
            @(posedge clk); #1;
            chk("b2b_rsp_valid", fe_rsp_valid, 1'b1);
            chk("b2b_hit", fe_rsp_hit, 1'b1);
            chk("b2b_data", fe_rsp_data, bedata(bb[i]));
            chk("b2b_ready", fe_req_ready, 1'b1);
        end
        fe_req_valid = 1'b0;
        @(posedge clk); #1;

        // Back-pressure.
        fe_rsp_ready = 1'b0;
        send(16'd1);
        fe_req_valid = 1'b1; fe_req_tag = 16'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", fe_rsp_valid, 1'b1);
            chk("bp_data", fe_rsp_data, bedata(16'd1));
            chk("bp_ready", fe_req_ready, 1'b0);
            chk("bp_no_accept", ev_acc, 1'b0);
        end
        fe_rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_accept", ev_acc, 1'b1);
        chk("bp_release_data", fe_rsp_data, bedata(16'd2));
        chk("bp_release_hit", fe_rsp_hit, 1'b1);
        fe_req_valid = 1'b0;

        // Flush in IDLE, then flush while the miss for tag 5 waits for data.
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        send(16'd5);
        wait_mwait();
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        get_rsp(h, d);
        chk("flush_fill_hit", h, 1'b0);
        chk("flush_fill_data", d, bedata(16'd5));
        do_req(16'd5, h, d);
        chk("after_flush_miss", h, 1'b0);

        // Reset while waiting for backend data, with a stale beat offered during reset.
        be_stall = 1'b1;
        send(16'h0077);
        wait_mwait();
        repeat (2) @(posedge clk);
        #1;
        be_stale = 1'b1; rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_be_rsp_ready", be_rsp_ready, 1'b0);
        end
        be_stale = 1'b0; be_stall = 1'b0; rstn = 1'b1;
        @(posedge clk); #1;
        do_req(16'd1, h, d);
        chk("post_rst_1_miss", h, 1'b0);
        chk("post_rst_1_data", d, bedata(16'd1));
        do_req(16'd2, h, d);
        chk("post_rst_2_miss", h, 1'b0);
`ifdef LRU_CACHE_STATS_EN
        chk("post_rst_stat_misses", stat_misses, 32'd2);
        chk("post_rst_stat_hits", stat_hits, 32'd0);
`endif

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (ev_acc) fe_req_valid = 1'b0;
            if (!fe_req_valid && $urandom_range(0, 2) != 0) begin
                fe_req_valid = 1'b1;
                fe_req_tag   = TW'($urandom_range(1, 12));
            end
            fe_rsp_ready = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 40) == 0);
        end
        flush = 1'b0; fe_rsp_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (ev_acc) fe_req_valid = 1'b0;
            if (!fe_req_valid && m_phase == 0 && !m_rsp_valid) break;
        end
        chk("drain_idle", (!fe_req_valid && m_phase == 0), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lru_cache_assoc.md
Name: lru_cache_assoc

Overview:
- Parametrised, fully-associative, blocking LRU cache placed between a 250 MHz-domain lookup client (frontend) and a slower backing store (backend).
- Frontend presents a tag and receives the associated data line. Hits are served from registered storage; misses fetch from the backend, fill the victim line and then respond.
- Generalises the fixed 8-entry lookup to arbitrary power-of-two depth, tag and data width, and adds miss fill, valid bits and flush.

Parameters:
- TAG_WIDTH, 48, width of lookup key.
- DATA_WIDTH, 512, width of one cache line.
- DEPTH, 8, number of lines; power of two, 2..64.
- IDX_W, $clog2(DEPTH), derived; not overridable.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- fe_req_valid  in  1  frontend lookup valid.
- fe_req_ready  out  1  frontend lookup ready.
- fe_req_tag  in  TAG_WIDTH  lookup key.
- fe_rsp_valid  out  1  response valid.
- fe_rsp_ready  in  1  response ready.
- fe_rsp_data  out  DATA_WIDTH  line data.
- fe_rsp_hit  out  1  1 = served from cache, 0 = served after fill.
- be_req_valid  out  1  backend fetch valid.
- be_req_ready  in  1  backend fetch ready.
- be_req_tag  out  TAG_WIDTH  tag to fetch.
- be_rsp_valid  in  1  backend data valid.
- be_rsp_ready  out  1  backend data ready.
- be_rsp_data  in  DATA_WIDTH  fetched line.
- flush  in  1  single-cycle pulse; invalidate all lines.

Behaviour:
- Reset (rstn=0 at posedge):
  - All valid bits 0; rank[i]=i; FSM=IDLE.
  - fe_rsp_valid=0, fe_rsp_hit=0, fe_rsp_data=0, be_req_valid=0, be_rsp_ready=0, be_req_tag=0; fe_req_ready=1 one cycle after reset release.
  - Reset mid-miss abandons the miss; a late be_rsp beat is ignored because be_rsp_ready=0.
- Handshakes:
  - valid/ready; a transfer occurs on a cycle with both high.
  - Once asserted, valid and payload hold until accepted.
- fe_req_ready:
  - =1 only when FSM=IDLE and (fe_rsp_valid=0 or fe_rsp_ready=1).
  - Allows one hit per cycle at full throughput.
- Lookup: a line hits when valid[i] and tag[i]==fe_req_tag. More than one match is impossible by construction.
- Hit:
  - fe_rsp_valid=1 on the cycle after acceptance (latency 1), with fe_rsp_data=data[i] and fe_rsp_hit=1.
  - LRU touch of i applied in the same edge.
- LRU:
  - Each line holds rank (IDX_W bits, 0=MRU); ranks always form a permutation of 0..DEPTH-1.
  - Touch of line e with rank r: every line with rank<r increments, then rank[e]=0.
- Miss (FSM):
  - IDLE -> MREQ on an accepted miss. Latch the tag, assert be_req_valid and be_req_tag.
  - MREQ -> MWAIT on be_req handshake; be_rsp_ready=1 in MWAIT.
  - MWAIT -> IDLE on be_rsp handshake. In that edge:
    - Write victim line: tag, data and valid=1, then touch the victim.
    - Assert fe_rsp_valid with be_rsp_data and fe_rsp_hit=0.
- Victim selection: lowest-index invalid line; if all lines are valid, the line with rank DEPTH-1.
- Flush:
  - In IDLE, clears all valid bits on the next edge; ranks are unchanged.
  - A flush in MREQ/MWAIT is latched and applied on the edge the FSM re-enters IDLE, after the fill (the filled line ends invalid; its response is still delivered).
  - A lookup accepted in the same cycle as a flush in IDLE uses the pre-flush contents.
- Back-pressure: while fe_rsp_valid=1 and fe_rsp_ready=0, fe_rsp_* hold stable and no new request is accepted.

Optional Feature:
- Macro: LRU_CACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits and stat_misses, 32 bits each.
  - Incremented on each accepted hit/miss; saturate at 0xFFFFFFFF; cleared by reset, not by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Cold miss: after reset, request tag 0x1234 → be_req_tag=0x1234; return data 0xAA..AA → fe_rsp_hit=0, data 0xAA..AA; repeat 0x1234 → hit=1, response 1 cycle after acceptance, no be_req.
- LRU eviction (DEPTH=8): fill tags 1..8, touch tag 1, request tag 9 → tag 2 evicted; request 2 → miss; request 1 → hit.
- Back-to-back hits with fe_rsp_ready=1 every cycle, tags 1,2,3 → three responses on consecutive cycles; fe_req_ready stays 1.
- Back-pressure: hold fe_rsp_ready=0 for 5 cycles after a hit → fe_rsp_data stable, fe_req_ready=0, no second response.
- Flush during MWAIT on tag 5 → response for 5 delivered (hit=0); subsequent request 5 → miss.
- Reset asserted in MWAIT, then tags 1 and 2 requested → both miss; a stale be_rsp_valid during reset is not accepted; with LRU_CACHE_STATS_EN, stat_misses=2 and stat_hits=0.
